// File: rtl/nibble_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder: slice width, the control
// FSM state encoding and a helper deriving the slice count from the width.
// ---------------------------------------------------------------------------
package nibble_serial_adder_pkg;

    // Width of the single carry-lookahead slice reused every RUN cycle.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slices needed to cover an operand of the given width.
    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_if
// Request/response bundle of the nibble-serial adder.
//   in_valid/in_ready   : operand handshake (a, b, c_in)
//   out_valid/out_ready : result handshake (sum, c_out, ovf)
//   busy                : adder is stepping through slices
// master = operand producer / result consumer, slave = the adder.
// ---------------------------------------------------------------------------
interface nibble_serial_adder_if #(
    parameter int WIDTH = 32
);
    import nibble_serial_adder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, busy
    );

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Combinational 4-bit carry-lookahead adder slice.
//   a, b : 4-bit addends        ci : carry in
//   s    : 4-bit sum            co : carry out of bit 3
//   c3   : carry into bit 3 (used for signed-overflow detection)
// ---------------------------------------------------------------------------
module cla4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               c3
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;
    logic               c3_int;
    logic               c4;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of generate/propagate terms,
    // so no carry ripples through another.
    assign c1     = g[0] | (p[0] & ci);
    assign c2     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3_int = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & ci);
    assign c4     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ {c3_int, c2, c1, ci};
    assign co = c4;
    assign c3 = c3_int;

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Adds two WIDTH-bit operands plus a carry-in by stepping one shared 4-bit
// carry-lookahead slice across the operands, least-significant nibble first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_if (operand/result handshakes,
//           sum, c_out, ovf, busy)
// Timing: accept edge -> NSLICE RUN cycles -> DONE. DONE spends one cycle
// with out_valid low before presenting the result, so out_valid rises
// NSLICE+1 edges after acceptance and stays high until out_ready.
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               carry_q,     carry_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               c_out_q,     c_out_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;

    // Nibble views of the latched operands, selected by the slice counter.
    logic [SLICE_W-1:0] a_nibs [NSLICE];
    logic [SLICE_W-1:0] b_nibs [NSLICE];

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_nib
        assign a_nibs[gi] = a_q[gi*SLICE_W +: SLICE_W];
        assign b_nibs[gi] = b_q[gi*SLICE_W +: SLICE_W];
    end

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               slice_c3;

    cla4_slice u_slice (
        .a  (a_nibs[cnt_q]),
        .b  (b_nibs[cnt_q]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (int'(cnt_q) == i) begin
                        sum_d[i*SLICE_W +: SLICE_W] = slice_s;
                    end
                end
                carry_d = slice_co;
                if (cnt_q == CNT_LAST) begin
                    // Signed overflow: carry into the MSB differs from the
                    // carry out of it, both seen in the top slice.
                    c_out_d = slice_co;
                    ovf_d   = slice_c3 ^ slice_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits; legal values are multiples of 4, range 8..64.
REQ-002 The block SHALL have derived constant NSLICE = WIDTH/4, meaning the number of 4-bit slices processed per operation.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  operand request.
REQ-006 Port in_ready  output  1  block can accept an operand request.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port c_in  input  1  carry into bit 0.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
REQ-013 Port c_out  output  1  carry out of bit WIDTH-1.
REQ-014 Port ovf  output  1  two's-complement signed overflow.
REQ-015 Port busy  output  1  high in RUN state.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, latch a, b, c_in into operand/carry registers, clear slice counter to 0, go to RUN.
REQ-018 RUN: each cycle, one shared 4-bit carry-lookahead slice adds nibble[cnt] of A and B with the carry register; result nibble written to sum[4*cnt+3:4*cnt]; carry register <= slice carry-out; cnt increments.
REQ-019 RUN: after the cycle with cnt==NSLICE-1, latch c_out and ovf, go to DONE; RUN lasts exactly NSLICE cycles.
REQ-020 Latency: out_valid SHALL rise NSLICE+1 cycles after the accepting edge (9 cycles at WIDTH=32).
REQ-021 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB, taken from the final slice.
REQ-022 DONE: out_valid=1; sum, c_out, ovf held stable until out_valid&&out_ready; then go to IDLE.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and operands not relatched.
REQ-024 Operand registers SHALL be used during RUN; changes on a/b/c_in after acceptance SHALL NOT affect the result.
REQ-025 sum SHALL retain its last value in IDLE; out_valid=0 in IDLE and RUN.
REQ-026 Counter SHALL be $clog2(NSLICE) bits and SHALL NOT wrap within an operation.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, cnt=0, operand/carry registers=0, sum=0, c_out=0, ovf=0, out_valid=0, busy=0; in_ready=1 once in IDLE.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation; no result SHALL be presented after reset release.
REQ-029 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the SLICE_W=4 constant.
REQ-031 The 4-bit slice SHALL be a sub-module cla4_slice (a[3:0], b[3:0], ci -> s[3:0], co, c3 = carry into bit 3), instantiated exactly once.

Verification
REQ-032 a=0xFFFFFFFF, b=0x00000001, c_in=0 -> after 9 cycles sum=0x00000000, c_out=1, ovf=0.
REQ-033 a=0x7FFFFFFF, b=0x00000001, c_in=0 -> sum=0x80000000, c_out=0, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, c_out=1, ovf=1.
REQ-034 a=0x12345678, b=0x0FEDCBA8, c_in=1 -> sum=0x22222221, c_out=0; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-035 New in_valid with a=0xDEADBEEF during RUN -> ignored; in-flight result unchanged; accepted only after return to IDLE.
REQ-036 rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately, out_valid never rises, next op a=3, b=4 -> sum=7.
REQ-037 Randomised 10,000 operations with random out_ready back-pressure, checked against a+b+c_in in a reference model.
